// File: rtl/lt24_bus_receiver_pkg.sv
// Shared LT24 bus definitions: command bytes, decoder states, default panel
// dimensions and the captured-bus record used by the receiver.
package lt24_bus_receiver_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int DEFAULT_WIDTH  = 240;
  localparam int DEFAULT_HEIGHT = 320;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COL    = 3'd1,
    ST_PAGE   = 3'd2,
    ST_MEMWR  = 3'd3,
    ST_IGNORE = 3'd4
  } dec_state_t;

  typedef struct packed {
    logic        wr_n;
    logic        rd_n;
    logic        cs_n;
    logic        rs;
    logic        panel_rst_n;
    logic [15:0] data;
  } bus_sample_t;

  localparam bus_sample_t BUS_IDLE = '{
    wr_n: 1'b1, rd_n: 1'b1, cs_n: 1'b1, rs: 1'b0, panel_rst_n: 1'b1, data: 16'h0000
  };

endpackage

// File: rtl/lt24_window_cursor.sv
// Column/page window registers with validation, and the memory-write cursor
// that walks the window in raster order and reports the end-of-frame position.
module lt24_window_cursor
  import lt24_bus_receiver_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       reinit,
  input  logic       arg_we,
  input  logic       arg_axis,
  input  logic [1:0] arg_idx,
  input  logic [7:0] arg_byte,
  input  logic       cursor_home,
  input  logic       advance,
  output logic [7:0] cur_x,
  output logic [8:0] cur_y,
  output logic       wrap,
  output logic       window_error
);

  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

  logic [15:0] xs_reg, xe_reg, ys_reg, ye_reg;
  logic [15:0] cx_reg, cy_reg;
  logic [7:0]  stage_reg [3];
  logic [15:0] cand_start, cand_end, cand_last;
  logic        cand_bad;
  logic        commit_axis;

  // The first three argument bytes are staged so a preempted sequence never
  // leaves a half-written, unvalidated window behind.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    always_ff @(posedge clock) begin
      if (!reset_n || reinit) begin
        stage_reg[gi] <= 8'h00;
      end else if (arg_we && arg_idx == 2'(gi)) begin
        stage_reg[gi] <= arg_byte;
      end
    end
  end

  always_comb begin
    cand_start   = {stage_reg[0], stage_reg[1]};
    cand_end     = {stage_reg[2], arg_byte};
    cand_last    = arg_axis ? Y_LAST : X_LAST;
    cand_bad     = (cand_start > cand_end) || (cand_end > cand_last);
    commit_axis  = arg_we && (arg_idx == 2'd3);
    window_error = commit_axis && cand_bad;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || reinit) begin
      xs_reg <= 16'h0000;
      xe_reg <= X_LAST;
      ys_reg <= 16'h0000;
      ye_reg <= Y_LAST;
      cx_reg <= 16'h0000;
      cy_reg <= 16'h0000;
    end else begin
      if (commit_axis && !arg_axis) begin
        xs_reg <= cand_bad ? 16'h0000 : cand_start;
        xe_reg <= cand_bad ? X_LAST : cand_end;
      end
      if (commit_axis && arg_axis) begin
        ys_reg <= cand_bad ? 16'h0000 : cand_start;
        ye_reg <= cand_bad ? Y_LAST : cand_end;
      end
      if (cursor_home) begin
        cx_reg <= xs_reg;
        cy_reg <= ys_reg;
      end else if (advance) begin
        if (cx_reg != xe_reg) begin
          cx_reg <= cx_reg + 16'd1;
        end else if (cy_reg != ye_reg) begin
          cx_reg <= xs_reg;
          cy_reg <= cy_reg + 16'd1;
        end else begin
          cx_reg <= xs_reg;
          cy_reg <= ys_reg;
        end
      end
    end
  end

  assign cur_x = cx_reg[7:0];
  assign cur_y = cy_reg[8:0];
  assign wrap  = (cx_reg == xe_reg) && (cy_reg == ye_reg);

endmodule

// File: rtl/lt24_bus_receiver.sv
// LT24 panel-side receiver: samples the write bus, decodes commands and
// reconstructs the pixel stream with a per-frame checksum and error flag.
module lt24_bus_receiver
  import lt24_bus_receiver_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        LT24Wr_n,
  input  logic        LT24Rd_n,
  input  logic        LT24CS_n,
  input  logic        LT24RS,
  input  logic        LT24Reset_n,
  input  logic [15:0] LT24Data,
  input  logic        LT24LCDOn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pixel_valid,
  output logic [7:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_data,
  output logic        frame_done,
  output logic [15:0] frame_checksum,
  output logic        protocol_error
);

  bus_sample_t bus_now, s1_reg, s2_reg;
  logic        wr_commit, rd_seen, panel_reinit;
  logic        ev_valid_reg, ev_rs_reg;
  logic [15:0] ev_data_reg;
  logic [15:0] acc_reg;
  logic [1:0]  arg_cnt_reg;
  dec_state_t  state_reg;

  logic        arg_we, arg_axis, cursor_home, advance;
  logic [7:0]  cur_x;
  logic [8:0]  cur_y;
  logic        wrap, window_error;
  logic        unused_lcd_on;

  assign unused_lcd_on = LT24LCDOn;

  assign bus_now = '{
    wr_n: LT24Wr_n, rd_n: LT24Rd_n, cs_n: LT24CS_n, rs: LT24RS,
    panel_rst_n: LT24Reset_n, data: LT24Data
  };

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_reg <= BUS_IDLE;
      s2_reg <= BUS_IDLE;
    end else begin
      s1_reg <= bus_now;
      s2_reg <= s1_reg;
    end
  end

  assign wr_commit    = s1_reg.wr_n && !s2_reg.wr_n && !s2_reg.cs_n;
  assign rd_seen      = !s2_reg.rd_n && !s2_reg.cs_n;
  assign panel_reinit = !s2_reg.panel_rst_n;

  // Extra stage between detection and decode sets the 3-edge input-to-output latency.
  always_ff @(posedge clock) begin
    if (!reset_n || panel_reinit) begin
      ev_valid_reg <= 1'b0;
      ev_rs_reg    <= 1'b0;
      ev_data_reg  <= 16'h0000;
    end else begin
      ev_valid_reg <= wr_commit;
      ev_rs_reg    <= s2_reg.rs;
      ev_data_reg  <= s2_reg.data;
    end
  end

  always_comb begin
    arg_we      = ev_valid_reg && ev_rs_reg && (state_reg == ST_COL || state_reg == ST_PAGE);
    arg_axis    = (state_reg == ST_PAGE);
    cursor_home = ev_valid_reg && !ev_rs_reg && (ev_data_reg[7:0] == CMD_RAMWR);
    advance     = ev_valid_reg && ev_rs_reg && (state_reg == ST_MEMWR);
  end

  lt24_window_cursor #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_window_cursor (
    .clock        (clock),
    .reset_n      (reset_n),
    .reinit       (panel_reinit),
    .arg_we       (arg_we),
    .arg_axis     (arg_axis),
    .arg_idx      (arg_cnt_reg),
    .arg_byte     (ev_data_reg[7:0]),
    .cursor_home  (cursor_home),
    .advance      (advance),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .wrap         (wrap),
    .window_error (window_error)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || panel_reinit) begin
      state_reg      <= ST_IDLE;
      arg_cnt_reg    <= 2'd0;
      acc_reg        <= 16'h0000;
      cmd_valid      <= 1'b0;
      cmd_code       <= 8'h00;
      pixel_valid    <= 1'b0;
      pixel_x        <= 8'h00;
      pixel_y        <= 9'h000;
      pixel_data     <= 16'h0000;
      frame_done     <= 1'b0;
      frame_checksum <= 16'h0000;
      protocol_error <= reset_n ? protocol_error : 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (rd_seen || window_error) begin
        protocol_error <= 1'b1;
      end
      if (ev_valid_reg && !ev_rs_reg) begin
        cmd_valid   <= 1'b1;
        cmd_code    <= ev_data_reg[7:0];
        arg_cnt_reg <= 2'd0;
        case (ev_data_reg[7:0])
          CMD_CASET: state_reg <= ST_COL;
          CMD_PASET: state_reg <= ST_PAGE;
          CMD_RAMWR: begin
            state_reg <= ST_MEMWR;
            acc_reg   <= 16'h0000;
          end
          default:   state_reg <= ST_IGNORE;
        endcase
      end else if (ev_valid_reg) begin
        case (state_reg)
          ST_COL, ST_PAGE: begin
            arg_cnt_reg <= arg_cnt_reg + 2'd1;
            if (arg_cnt_reg == 2'd3) begin
              state_reg <= ST_IDLE;
            end
          end
          ST_MEMWR: begin
            pixel_valid <= 1'b1;
            pixel_x     <= cur_x;
            pixel_y     <= cur_y;
            pixel_data  <= ev_data_reg;
            if (wrap) begin
              frame_done     <= 1'b1;
              frame_checksum <= acc_reg + ev_data_reg;
              acc_reg        <= 16'h0000;
            end else begin
              acc_reg <= acc_reg + ev_data_reg;
            end
          end
          ST_IDLE: protocol_error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/lt24_bus_receiver.md
# lt24_bus_receiver

Panel-side receiver for the LT24 parallel write bus: the far end of the LT24 display driver. It samples the LT24 strobes and data on the system clock, decodes command and data writes, and tracks the column/page window and the memory-write cursor. It reconstructs the pixel stream as (x, y, rgb) beats, emits a per-frame checksum, and flags protocol violations. It sits beside the display driver in simulation and on-chip self-test, so game graphics can be checked without a physical panel.

## Interface
- WIDTH, 240, panel columns; must be ≤ 256.
- HEIGHT, 320, panel rows; must be ≤ 512.
- clock  in  1  system clock, 50 MHz; the same clock that drives the LT24 driver.
- reset_n  in  1  synchronous, active-low reset.
- LT24Wr_n  in  1  write strobe; a write is committed on its rising edge.
- LT24Rd_n  in  1  read strobe; reads are unsupported.
- LT24CS_n  in  1  chip select, active-low.
- LT24RS  in  1  0 = command, 1 = data.
- LT24Reset_n  in  1  panel reset, active-low.
- LT24Data  in  16  bus data; commands and arguments use bits [7:0].
- LT24LCDOn  in  1  backlight; status only.
- cmd_valid  out  1  one-cycle pulse per decoded command.
- cmd_code  out  8  last command byte.
- pixel_valid  out  1  one-cycle pulse per pixel written.
- pixel_x  out  8  column of the pixel.
- pixel_y  out  9  row of the pixel.
- pixel_data  out  16  RGB565 value of the pixel.
- frame_done  out  1  one-cycle pulse when the cursor wraps past the window end.
- frame_checksum  out  16  sum mod 2^16 of every pixel in the completed frame.
- protocol_error  out  1  sticky error flag.

## Operation
- **Input capture.** All LT24 inputs pass through two register stages, s1 then s2.
- **Write detection.** A write is committed when s1.Wr_n = 1, s2.Wr_n = 0 and s2.CS_n = 0. RS and Data are taken from s2.
- **Read detection.** s2.Rd_n = 0 with s2.CS_n = 0 sets protocol_error.
- **Decoder states.** IDLE, COL, PAGE, MEMWR, IGNORE.
- **Command write (RS = 0).** Pulse cmd_valid and load cmd_code. Then:
  - 0x2A → COL with argument count 0.
  - 0x2B → PAGE with argument count 0.
  - 0x2C → MEMWR; cursor set to (xs, ys); checksum accumulator cleared.
  - any other command → IGNORE.
  - A command always preempts any partially received arguments.
- **COL data.** The argument bytes load xs[15:8], xs[7:0], xe[15:8], xe[7:0] in that order. After the fourth byte, go to IDLE and validate the window. Internally xs/xe are 16 bits wide; pixel_x is their low 8 bits.
- **PAGE data.** Same sequence, loading ys and ye.
- **Window validation.** If start > end, or end ≥ WIDTH (for x) or ≥ HEIGHT (for y):
  - set protocol_error;
  - force that axis to its full range: 0..WIDTH−1 or 0..HEIGHT−1.
- **MEMWR data.** Emit a pixel at (cx, cy) and add the data to the checksum. Then advance the cursor:
  - cx ≠ xe → cx+1;
  - cx = xe, cy ≠ ye → cx = xs, cy+1;
  - cx = xe, cy = ye → cursor to (xs, ys); pulse frame_done; frame_checksum = accumulator plus this pixel; accumulator cleared.
- **Data in IDLE.** Set protocol_error and drop the write.
- **Data in IGNORE.** Silently drop the write.
- **Panel reset.** When s2.LT24Reset_n = 0, reinitialise exactly as reset_n does, except protocol_error is kept.
- **Reset values.** Window 0..WIDTH−1 × 0..HEIGHT−1, cursor (0, 0), state IDLE. All outputs are 0: cmd_code, pixel bus, frame_checksum, the pulse outputs and protocol_error.

## Timing
- Outputs are registered. Every pulse is asserted exactly one cycle.
- Latency: a pulse appears on the second clock edge after the first edge that samples LT24Wr_n high. That is 3 edges from the input transition to the output being visible.
- pixel_x, pixel_y and pixel_data are valid in the pulse cycle and hold until the next pixel.
- frame_done and frame_checksum update in the same cycle as the final pixel_valid.
- The Wr_n low and high phases must each last at least 1 cycle. Back-to-back writes with a 2-cycle period must be accepted losslessly.
- reset_n is sampled on the rising clock edge only. Asserting it mid-frame discards the partial frame, with no frame_done.

## Structure
- Shared include lt24_defs: command constants CMD_CASET = 0x2A, CMD_PASET = 0x2B, CMD_RAMWR = 0x2C; decoder state encodings; default panel dimensions.
- Sub-module lt24_window_cursor holds:
  - window registers and validation/clamping;
  - cursor advance and wrap;
  - the frame_done condition.
- The top level holds input capture, write detection, the decoder FSM and the checksum.

## Test plan
- **Full-screen frame.** After reset, send 0x2C then 76800 writes of 0x0001 → pixels raster (0,0)..(239,319); one frame_done on the last pixel; frame_checksum = 76800 mod 65536 = 0x2C00.
- **Window and wrap.** CASET 0,10,0,12 / PASET 0,5,0,6 / RAMWR with 7 words → pixels (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), frame_done, then (10,5).
- **Invalid window.** CASET with xs = 20, xe = 10 → protocol_error = 1; the window becomes 0..239; the next RAMWR starts at (0, y-start).
- **Data without command, and reads.** A data write after reset → protocol_error = 1 with no pixel. Separately, Rd_n low with CS_n low → protocol_error = 1.
- **Interrupted stream.** Issue RAMWR and 3 pixels, pulse LT24Reset_n low, then RAMWR again → cursor restarts at (0, 0) with no frame_done and protocol_error unchanged. Separately, reset_n low for 1 cycle mid-stream → all outputs return to 0.
- **Strobe gating and max rate.** Wr_n toggling with CS_n high → no outputs. Writes at a 2-cycle period → every write is reported.
